multicycle_seq_ctrl: RTL and testbench
======================================

Name: multicycle_seq_ctrl

Overview:
- Multicycle sequencer for the WISC-SP13 datapath. Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB.
- Drives the PC, instruction register, register file and memory enables.
- Handles variable-latency instruction/data memory through a done handshake with a timeout.
- Stops permanently on HALT (opcode 00000), on an illegal opcode, or on a memory timeout.
- Sits between the instruction register / opcode decoder and the datapath storage elements.

Parameters:
- MEM_TIMEOUT, 16: max cycles spent in FETCH or MEM waiting for done before the error state.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- opcode  in  5  Instr[15:11] from the instruction register; valid from DECODE onward
- imem_done  in  1  instruction memory read complete (data valid this cycle)
- dmem_done  in  1  data memory access complete
- imem_en  out  1  instruction fetch request
- ir_en  out  1  instruction register load
- dmem_en  out  1  data memory request
- dmem_wr  out  1  data memory write (valid with dmem_en)
- rf_we  out  1  register file write enable
- pc_en  out  1  PC update enable
- retire  out  1  one-cycle pulse per retired instruction
- retire_cnt  out  CNT_W  count of retired instructions, wraps
- halted  out  1  sticky; HALT executed
- err  out  1  sticky; illegal opcode or memory timeout
- state  out  3  current state (debug)

Behaviour:
- Reset: rst is synchronous, active-high and wins over all other inputs in every state, including mid-MEM or mid-FETCH.
  - State goes to FETCH; retire_cnt=0; halted=0; err=0; timer=0.
  - All outputs are 0 while rst is high.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5, ERR=6.
- FETCH: imem_en=1 every cycle.
  - If imem_done=1: ir_en=1 in the same cycle; next state DECODE.
  - Otherwise the timer increments.
  - If timer==MEM_TIMEOUT-1 and imem_done=0: next state ERR. A done on the MEM_TIMEOUT-th cycle is still accepted.
- DECODE: classify opcode and latch the class flags (is_mem, is_store, writes_reg, is_halt, illegal).
  - illegal (00010, 00011): go to ERR.
  - is_halt: go to HALTED.
  - Otherwise: go to EXEC.
- EXEC: one cycle with no enables. Next state is MEM if is_mem, else WB.
- MEM (ST 10000, LD 10001, STU 10011): dmem_en=1; dmem_wr=is_store (ST, STU).
  - Held until dmem_done=1, then next state WB.
  - Timeout rule is identical to FETCH.
- WB: pc_en=1; rf_we=writes_reg; retire=1; retire_cnt+1 (wraps at 2^CNT_W); next state FETCH.
- writes_reg = 0 for:
  - HALT, NOP
  - J (00100), JR (00101)
  - ST
  - branches 011xx
- writes_reg = 1 for all other legal opcodes, including STU, JAL and JALR.
- Timer: cleared on every entry to FETCH or MEM. Width is clog2(MEM_TIMEOUT)+1.
- HALTED: halted=1; all enables 0; absorbing; exits only via rst. HALT does not retire.
- ERR: err=1; all enables 0; absorbing; exits only via rst. No retire.
- imem_done and dmem_done are ignored outside FETCH and MEM respectively.
- opcode is ignored in every state except DECODE.
- Latency with zero-wait memory (done high on the first request cycle):
  - non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB)
  - memory instruction: 5 cycles
  - each wait cycle adds 1.

Decomposition:
- Shared include file seq_ctrl_defs.v: state encodings, and opcode constants for HALT, NOP, ST, LD, STU, J, JR, the branch prefix 011, and the illegal codes.
- One sub-module, op_class: combinational decode of opcode into is_mem, is_store, writes_reg, is_halt and illegal. It is reused by the pipelined design later.
- The FSM, timer and retire counter live in multicycle_seq_ctrl.

Test Plan:
- Reset, then ADDI (01000) with imem_done held 1:
  - states 0,1,2,4
  - rf_we=1 and pc_en=1 only in cycle 4
  - retire_cnt=1 after WB.
- ST (10000), imem_done=1, dmem_done asserted on the 3rd MEM cycle:
  - dmem_en=1 and dmem_wr=1 for 3 cycles
  - rf_we=0 in WB
  - total 7 cycles.
- LD (10001) with imem_done low for 15 cycles then high: accepted, no err. Repeat with imem_done never high: state=6 and err=1 after exactly 16 FETCH cycles.
- HALT (00000): halted=1 from the cycle after DECODE; retire stays 0; imem_en stays 0 for 20 further cycles.
- Opcode 00011 → state=6, err=1, pc_en never asserted. Then rst pulse → state=0, err=0, retire_cnt=0.
- rst asserted mid-MEM of STU (10011): next cycle state=0, dmem_en=0, no rf_we/retire; after release, a normal fetch resumes.

Source files
------------

// File: rtl/multicycle_seq_ctrl_pkg.sv
// ============================================================================
// multicycle_seq_ctrl_pkg : shared state encodings and WISC-SP13 opcode codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package multicycle_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_ILL0 = 5'b00010;
  localparam logic [4:0] OP_ILL1 = 5'b00011;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_STU  = 5'b10011;

  // Upper three opcode bits shared by all conditional branches
  localparam logic [2:0] OP_BR_PFX = 3'b011;

endpackage

`default_nettype wire

// File: rtl/multicycle_seq_ctrl_if.sv
// ============================================================================
// multicycle_seq_ctrl_if : sequencer <-> datapath/memory control bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface multicycle_seq_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       opcode;
  logic             imem_done;
  logic             dmem_done;
  logic             imem_en;
  logic             ir_en;
  logic             dmem_en;
  logic             dmem_wr;
  logic             rf_we;
  logic             pc_en;
  logic             retire;
  logic [CNT_W-1:0] retire_cnt;
  logic             halted;
  logic             err;
  logic [2:0]       state;

  modport master (
    input  opcode, imem_done, dmem_done,
    output imem_en, ir_en, dmem_en, dmem_wr, rf_we, pc_en,
    output retire, retire_cnt, halted, err, state
  );

  modport slave (
    output opcode, imem_done, dmem_done,
    input  imem_en, ir_en, dmem_en, dmem_wr, rf_we, pc_en,
    input  retire, retire_cnt, halted, err, state
  );

endinterface

`default_nettype wire

// File: rtl/multicycle_seq_ctrl_op_class.sv
// ============================================================================
// op_class : combinational opcode classifier (shared with the pipelined core)
// Revision: 1.0
// ============================================================================
`default_nettype none

module op_class
  import multicycle_seq_ctrl_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic       is_mem_o,
  output logic       is_store_o,
  output logic       writes_reg_o,
  output logic       is_halt_o,
  output logic       illegal_o
);

  always_comb begin
    is_mem_o     = 1'b0;
    is_store_o   = 1'b0;
    writes_reg_o = 1'b1;
    is_halt_o    = 1'b0;
    illegal_o    = 1'b0;
    case (opcode_i)
      OP_HALT: begin
        is_halt_o    = 1'b1;
        writes_reg_o = 1'b0;
      end
      OP_NOP, OP_J, OP_JR: writes_reg_o = 1'b0;
      OP_ILL0, OP_ILL1: begin
        illegal_o    = 1'b1;
        writes_reg_o = 1'b0;
      end
      OP_ST: begin
        is_mem_o     = 1'b1;
        is_store_o   = 1'b1;
        writes_reg_o = 1'b0;
      end
      OP_LD:  is_mem_o = 1'b1;
      // STU stores and also writes the updated base register back
      OP_STU: begin
        is_mem_o   = 1'b1;
        is_store_o = 1'b1;
      end
      default: begin
        if (opcode_i[4:2] == OP_BR_PFX) writes_reg_o = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_seq_ctrl.sv
// ============================================================================
// multicycle_seq_ctrl : FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_seq_ctrl
  import multicycle_seq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic                   clk,
  input logic                   rst,
  multicycle_seq_ctrl_if.master ctrl_io
);

  localparam int              TMR_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic             is_mem_q, is_mem_d;
  logic             is_store_q, is_store_d;
  logic             writes_reg_q, writes_reg_d;

  logic dec_is_mem, dec_is_store, dec_writes_reg, dec_is_halt, dec_illegal;
  logic imem_en, ir_en, dmem_en, dmem_wr, rf_we, pc_en, retire;

  op_class u_op_class (
    .opcode_i     (ctrl_io.opcode),
    .is_mem_o     (dec_is_mem),
    .is_store_o   (dec_is_store),
    .writes_reg_o (dec_writes_reg),
    .is_halt_o    (dec_is_halt),
    .illegal_o    (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      timer_q      <= '0;
      retire_cnt_q <= '0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
      is_mem_q     <= 1'b0;
      is_store_q   <= 1'b0;
      writes_reg_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retire_cnt_q <= retire_cnt_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
      is_mem_q     <= is_mem_d;
      is_store_q   <= is_store_d;
      writes_reg_q <= writes_reg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    retire_cnt_d = retire_cnt_q;
    halted_d     = halted_q;
    err_d        = err_q;
    is_mem_d     = is_mem_q;
    is_store_d   = is_store_q;
    writes_reg_d = writes_reg_q;
    imem_en      = 1'b0;
    ir_en        = 1'b0;
    dmem_en      = 1'b0;
    dmem_wr      = 1'b0;
    rf_we        = 1'b0;
    pc_en        = 1'b0;
    retire       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_en = 1'b1;
        // done is checked before the timeout so the last allowed cycle still completes
        if (ctrl_io.imem_done) begin
          ir_en   = 1'b1;
          state_d = ST_DECODE;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DECODE: begin
        is_mem_d     = dec_is_mem;
        is_store_d   = dec_is_store;
        writes_reg_d = dec_writes_reg;
        if (dec_illegal) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (dec_is_halt) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_mem_q) begin
          state_d = ST_MEM;
          timer_d = '0;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_en = 1'b1;
        dmem_wr = is_store_q;
        if (ctrl_io.dmem_done) begin
          state_d = ST_WB;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WB: begin
        pc_en        = 1'b1;
        rf_we        = writes_reg_q;
        retire       = 1'b1;
        retire_cnt_d = retire_cnt_q + 1'b1;
        state_d      = ST_FETCH;
        timer_d      = '0;
      end
      default: begin
      end
    endcase
  end

  // Reset forces every output low in the same cycle, whatever the state register holds
  assign ctrl_io.imem_en    = imem_en & ~rst;
  assign ctrl_io.ir_en      = ir_en & ~rst;
  assign ctrl_io.dmem_en    = dmem_en & ~rst;
  assign ctrl_io.dmem_wr    = dmem_wr & ~rst;
  assign ctrl_io.rf_we      = rf_we & ~rst;
  assign ctrl_io.pc_en      = pc_en & ~rst;
  assign ctrl_io.retire     = retire & ~rst;
  assign ctrl_io.retire_cnt = rst ? '0 : retire_cnt_q;
  assign ctrl_io.halted     = halted_q & ~rst;
  assign ctrl_io.err        = err_q & ~rst;
  assign ctrl_io.state      = rst ? 3'd0 : state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_seq_ctrl.sv
// ============================================================================
// tb_multicycle_seq_ctrl : directed self-checking bench for multicycle_seq_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  multicycle_seq_ctrl_if #(.CNT_W(16)) bus ();

  multicycle_seq_ctrl #(
    .MEM_TIMEOUT (16),
    .CNT_W       (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus)
  );

  always #5 clk = ~clk;

  // {imem_en, ir_en, dmem_en, dmem_wr, rf_we, pc_en, retire}
  logic [6:0] en;
  assign en = {bus.imem_en, bus.ir_en, bus.dmem_en, bus.dmem_wr,
               bus.rf_we, bus.pc_en, bus.retire};

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one cycle (state, enables, {halted,err}) mid-cycle, then advance
  task automatic cyc(input string tag, input logic [2:0] st, input logic [6:0] e,
                     input logic [1:0] he);
    #2;
    check_val({tag, "/state"}, 32'(bus.state), 32'(st));
    check_val({tag, "/en"}, 32'(en), 32'(e));
    check_val({tag, "/halt_err"}, 32'({bus.halted, bus.err}), 32'(he));
    tick();
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp);
    check_val(tag, 32'(bus.retire_cnt), 32'(exp));
  endtask

  task automatic rst_pulse(input string tag);
    rst = 1'b1;
    cyc(tag, 3'd0, 7'b0, 2'b00);
    rst           = 1'b0;
    bus.imem_done = 1'b0;
    bus.dmem_done = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.opcode    = 5'b0;
    bus.imem_done = 1'b0;
    bus.dmem_done = 1'b0;
    tick();
    tick();
    // outputs must stay low under reset even with done inputs high
    bus.imem_done = 1'b1;
    bus.dmem_done = 1'b1;
    bus.opcode    = 5'b10000;
    rst_pulse("reset");
    check_cnt("reset_cnt", 16'd0);

    // ADDI: FETCH, DECODE, EXEC, WB
    bus.opcode    = 5'b01000;
    bus.imem_done = 1'b1;
    cyc("addi_f", 3'd0, 7'b1100000, 2'b00);
    cyc("addi_d", 3'd1, 7'b0000000, 2'b00);
    cyc("addi_e", 3'd2, 7'b0000000, 2'b00);
    bus.imem_done = 1'b0;
    cyc("addi_wb", 3'd4, 7'b0000111, 2'b00);
    check_cnt("addi_cnt", 16'd1);

    // ST with dmem_done on 3rd MEM cycle: 7 cycles total
    bus.opcode    = 5'b10000;
    bus.imem_done = 1'b1;
    cyc("st_f", 3'd0, 7'b1100000, 2'b00);
    bus.imem_done = 1'b0;
    cyc("st_d", 3'd1, 7'b0000000, 2'b00);
    cyc("st_e", 3'd2, 7'b0000000, 2'b00);
    cyc("st_m1", 3'd3, 7'b0011000, 2'b00);
    cyc("st_m2", 3'd3, 7'b0011000, 2'b00);
    bus.dmem_done = 1'b1;
    cyc("st_m3", 3'd3, 7'b0011000, 2'b00);
    bus.dmem_done = 1'b0;
    cyc("st_wb", 3'd4, 7'b0000011, 2'b00);
    check_cnt("st_cnt", 16'd2);

    // LD with 15 fetch wait cycles, done on the 16th: accepted
    bus.opcode = 5'b10001;
    for (int i = 0; i < 15; i++) cyc("ld_wait", 3'd0, 7'b1000000, 2'b00);
    bus.imem_done = 1'b1;
    cyc("ld_f16", 3'd0, 7'b1100000, 2'b00);
    bus.imem_done = 1'b0;
    cyc("ld_d", 3'd1, 7'b0000000, 2'b00);
    cyc("ld_e", 3'd2, 7'b0000000, 2'b00);
    bus.dmem_done = 1'b1;
    cyc("ld_m", 3'd3, 7'b0010000, 2'b00);
    bus.dmem_done = 1'b0;
    cyc("ld_wb", 3'd4, 7'b0000111, 2'b00);
    check_cnt("ld_cnt", 16'd3);

    // Fetch timeout: exactly 16 FETCH cycles then ERR
    for (int i = 0; i < 16; i++) cyc("ftmo_wait", 3'd0, 7'b1000000, 2'b00);
    cyc("ftmo_err", 3'd6, 7'b0000000, 2'b01);
    bus.imem_done = 1'b1;
    cyc("ftmo_stay", 3'd6, 7'b0000000, 2'b01);
    check_cnt("ftmo_cnt", 16'd3);
    rst_pulse("ftmo_rst");
    check_cnt("ftmo_rst_cnt", 16'd0);

    // HALT: absorbing, no retire, no fetch for 20 cycles
    bus.opcode    = 5'b00000;
    bus.imem_done = 1'b1;
    cyc("halt_f", 3'd0, 7'b1100000, 2'b00);
    cyc("halt_d", 3'd1, 7'b0000000, 2'b00);
    for (int i = 0; i < 20; i++) cyc("halt_stay", 3'd5, 7'b0000000, 2'b10);
    check_cnt("halt_cnt", 16'd0);
    rst_pulse("halt_rst");

    // NOP retires without a register write
    bus.opcode    = 5'b00001;
    bus.imem_done = 1'b1;
    cyc("nop_f", 3'd0, 7'b1100000, 2'b00);
    bus.imem_done = 1'b0;
    cyc("nop_d", 3'd1, 7'b0000000, 2'b00);
    cyc("nop_e", 3'd2, 7'b0000000, 2'b00);
    cyc("nop_wb", 3'd4, 7'b0000011, 2'b00);
    check_cnt("nop_cnt", 16'd1);

    // Illegal opcode 00011 -> ERR, then reset clears everything
    bus.opcode    = 5'b00011;
    bus.imem_done = 1'b1;
    cyc("ill_f", 3'd0, 7'b1100000, 2'b00);
    bus.imem_done = 1'b0;
    cyc("ill_d", 3'd1, 7'b0000000, 2'b00);
    for (int i = 0; i < 5; i++) cyc("ill_stay", 3'd6, 7'b0000000, 2'b01);
    check_cnt("ill_cnt", 16'd1);
    rst_pulse("ill_rst");
    check_cnt("ill_rst_cnt", 16'd0);
    cyc("ill_post", 3'd0, 7'b1000000, 2'b00);

    // STU interrupted by reset while in MEM
    bus.opcode    = 5'b10011;
    bus.imem_done = 1'b1;
    cyc("stu_f", 3'd0, 7'b1100000, 2'b00);
    bus.imem_done = 1'b0;
    cyc("stu_d", 3'd1, 7'b0000000, 2'b00);
    cyc("stu_e", 3'd2, 7'b0000000, 2'b00);
    cyc("stu_m", 3'd3, 7'b0011000, 2'b00);
    rst_pulse("stu_rst");
    check_cnt("stu_cnt", 16'd0);

    // Normal resume with JAL (writes link register)
    bus.opcode    = 5'b00110;
    bus.imem_done = 1'b1;
    cyc("jal_f", 3'd0, 7'b1100000, 2'b00);
    bus.imem_done = 1'b0;
    cyc("jal_d", 3'd1, 7'b0000000, 2'b00);
    cyc("jal_e", 3'd2, 7'b0000000, 2'b00);
    cyc("jal_wb", 3'd4, 7'b0000111, 2'b00);
    check_cnt("jal_cnt", 16'd1);

    // Branch 01101; dmem_done during FETCH must be ignored
    bus.opcode    = 5'b01101;
    bus.dmem_done = 1'b1;
    cyc("br_wait", 3'd0, 7'b1000000, 2'b00);
    bus.dmem_done = 1'b0;
    bus.imem_done = 1'b1;
    cyc("br_f", 3'd0, 7'b1100000, 2'b00);
    bus.imem_done = 1'b0;
    cyc("br_d", 3'd1, 7'b0000000, 2'b00);
    cyc("br_e", 3'd2, 7'b0000000, 2'b00);
    cyc("br_wb", 3'd4, 7'b0000011, 2'b00);
    check_cnt("br_cnt", 16'd2);

    // LD with data memory never responding: 16 MEM cycles then ERR
    bus.opcode    = 5'b10001;
    bus.imem_done = 1'b1;
    cyc("mtmo_f", 3'd0, 7'b1100000, 2'b00);
    bus.imem_done = 1'b0;
    cyc("mtmo_d", 3'd1, 7'b0000000, 2'b00);
    cyc("mtmo_e", 3'd2, 7'b0000000, 2'b00);
    for (int i = 0; i < 16; i++) cyc("mtmo_wait", 3'd3, 7'b0010000, 2'b00);
    cyc("mtmo_err", 3'd6, 7'b0000000, 2'b01);
    check_cnt("mtmo_cnt", 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
